// File: rtl/mem_excep_stage.sv
// EX -> cp0 pipeline register: captures the EX instruction, adds data-address
// alignment faults, tracks branch delay slots and kills faulting memory accesses.
module mem_excep_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_excep_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic [1:0]  ex_mem_size_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] exception_type_o,
  output logic [31:0] exception_addr_o,
  output logic        now_in_delayslot_o,
  output logic        mem_kill_o
);

  // Upstream bits carried forward: fetch AdEL, RI, Ov, Bp, Sys, ERET.
  localparam logic [31:0] KEEP_MASK = 32'hF800_0001;

  logic        r_valid;
  logic        r_ds;
  logic        r_slot_pending;
  logic [31:0] r_pc;
  logic [31:0] r_excep;
  logic [31:0] r_addr;

  logic        w_mis;
  logic        w_adel;
  logic        w_ades;
  logic [31:0] w_excep;
  logic [31:0] w_addr;

  always_comb begin
    w_mis   = ((ex_mem_size_i == 2'd1) && ex_mem_addr_i[0])
           || (ex_mem_size_i[1] && (ex_mem_addr_i[1:0] != 2'b00));
    // A combined rd/wr access reports only the store fault.
    w_ades  = ex_mem_wr_i & w_mis;
    w_adel  = ex_mem_rd_i & ~ex_mem_wr_i & w_mis;
    w_excep = (ex_excep_i & KEEP_MASK) | {5'b0, w_adel, w_ades, 25'b0};
    if (w_adel || w_ades)
      w_addr = ex_mem_addr_i;
    else if (ex_excep_i[31])
      w_addr = ex_pc_i;
    else
      w_addr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_excep        <= '0;
      r_addr         <= '0;
      r_ds           <= 1'b0;
      r_slot_pending <= 1'b0;
    end else if (flush_i) begin
      r_valid        <= 1'b0;
      r_excep        <= '0;
      r_addr         <= '0;
      r_ds           <= 1'b0;
      r_slot_pending <= 1'b0;
    end else if (!stall_i) begin
      r_valid <= ex_valid_i;
      r_pc    <= ex_pc_i;
      r_excep <= w_excep;
      r_addr  <= w_addr;
      r_ds    <= ex_valid_i & r_slot_pending;
      // Bubbles must not consume a pending delay slot.
      if (ex_valid_i)
        r_slot_pending <= ex_is_branch_i;
    end
  end

  assign valid_o            = r_valid;
  assign pc_o               = r_pc;
  assign exception_addr_o   = r_addr;
  assign exception_type_o   = r_valid ? r_excep : '0;
  assign now_in_delayslot_o = r_valid & r_ds;
  assign mem_kill_o         = r_valid & (r_excep != '0);

endmodule

// File: tb/tb_mem_excep_stage.sv
// Vector/scoreboard bench for mem_excep_stage: each record drives one edge and
// carries the outputs expected for the following cycle.
module tb_mem_excep_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_excep_i;
  logic        ex_is_branch_i;
  logic        ex_mem_rd_i;
  logic        ex_mem_wr_i;
  logic [1:0]  ex_mem_size_i;
  logic [31:0] ex_mem_addr_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] exception_type_o;
  logic [31:0] exception_addr_o;
  logic        now_in_delayslot_o;
  logic        mem_kill_o;

  mem_excep_stage dut (
    .clk                (clk),
    .rst                (rst),
    .ex_valid_i         (ex_valid_i),
    .ex_pc_i            (ex_pc_i),
    .ex_excep_i         (ex_excep_i),
    .ex_is_branch_i     (ex_is_branch_i),
    .ex_mem_rd_i        (ex_mem_rd_i),
    .ex_mem_wr_i        (ex_mem_wr_i),
    .ex_mem_size_i      (ex_mem_size_i),
    .ex_mem_addr_i      (ex_mem_addr_i),
    .stall_i            (stall_i),
    .flush_i            (flush_i),
    .valid_o            (valid_o),
    .pc_o               (pc_o),
    .exception_type_o   (exception_type_o),
    .exception_addr_o   (exception_addr_o),
    .now_in_delayslot_o (now_in_delayslot_o),
    .mem_kill_o         (mem_kill_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] typ;
    logic [31:0] addr;
    logic        ds;
    logic        kill;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic [31:0] exc;
    logic        br;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic        st;
    logic        fl;
    exp_t        e;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        exp_q[$];
  vec_t        tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                              input logic [31:0] exc, input logic br, input logic rd,
                              input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic st, input logic fl,
                              input logic ev, input logic [31:0] et, input logic [31:0] ea,
                              input logic eds, input logic ek, input logic [31:0] epc);
    vec_t x;
    x.rst = r;  x.v = v;  x.pc = pc;  x.exc = exc;  x.br = br;
    x.rd = rd;  x.wr = wr;  x.sz = sz;  x.addr = addr;  x.st = st;  x.fl = fl;
    x.e.valid = ev;  x.e.typ = et;  x.e.addr = ea;  x.e.ds = eds;  x.e.kill = ek;  x.e.pc = epc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step(input vec_t x);
    exp_t e;
    @(negedge clk);
    rst = x.rst;  ex_valid_i = x.v;  ex_pc_i = x.pc;  ex_excep_i = x.exc;
    ex_is_branch_i = x.br;  ex_mem_rd_i = x.rd;  ex_mem_wr_i = x.wr;
    ex_mem_size_i = x.sz;  ex_mem_addr_i = x.addr;  stall_i = x.st;  flush_i = x.fl;
    exp_q.push_back(x.e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      chk("valid_o",  {31'b0, valid_o}, {31'b0, e.valid});
      chk("exc_type", exception_type_o, e.typ);
      chk("exc_addr", exception_addr_o, e.addr);
      chk("ds",       {31'b0, now_in_delayslot_o}, {31'b0, e.ds});
      chk("kill",     {31'b0, mem_kill_o}, {31'b0, e.kill});
      chk("pc_o",     pc_o, e.pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    //             rst v pc            exc           br rd wr sz addr          st fl | v type          addr          ds k pc
    // reset with live-looking EX inputs, then idle bubble
    tbl.push_back(mk(1,1,32'hbfc00010,32'h40000000,1,1,0,2,32'h80000001,0,0, 0,32'h0,        32'h0,        0,0,32'h0));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0,0,32'h0,       0,0, 0,32'h0,        32'h0,        0,0,32'h0));
    // aligned LW
    tbl.push_back(mk(0,1,32'hbfc00100,32'h0,       0,1,0,2,32'h80000004,0,0, 1,32'h0,        32'h0,        0,0,32'hbfc00100));
    // misaligned LH -> AdEL
    tbl.push_back(mk(0,1,32'hbfc00200,32'h0,       0,1,0,1,32'h80000001,0,0, 1,32'h04000000,32'h80000001,0,1,32'hbfc00200));
    // misaligned SW -> AdES
    tbl.push_back(mk(0,1,32'hbfc00204,32'h0,       0,0,1,2,32'h80000002,0,0, 1,32'h02000000,32'h80000002,0,1,32'hbfc00204));
    // SB never misaligned
    tbl.push_back(mk(0,1,32'hbfc00208,32'h0,       0,0,1,0,32'h80000002,0,0, 1,32'h0,        32'h0,        0,0,32'hbfc00208));
    // rd and wr both set -> only AdES
    tbl.push_back(mk(0,1,32'hbfc0020c,32'h0,       0,1,1,1,32'h80000003,0,0, 1,32'h02000000,32'h80000003,0,1,32'hbfc0020c));
    // size 3 behaves as word
    tbl.push_back(mk(0,1,32'hbfc00210,32'h0,       0,1,0,3,32'h80000002,0,0, 1,32'h04000000,32'h80000002,0,1,32'hbfc00210));
    // ignored upstream bits are dropped
    tbl.push_back(mk(0,1,32'hbfc00214,32'h07fffffe,0,1,0,2,32'h80000000,0,0, 1,32'h0,        32'h0,        0,0,32'hbfc00214));
    // ERET alone kills
    tbl.push_back(mk(0,1,32'hbfc00218,32'h00000001,0,0,0,0,32'h0,       0,0, 1,32'h00000001,32'h0,        0,1,32'hbfc00218));
    // Ov + Bp passed through together
    tbl.push_back(mk(0,1,32'hbfc0021c,32'h30000000,0,0,0,0,32'h0,       0,0, 1,32'h30000000,32'h0,        0,1,32'hbfc0021c));
    // fetch fault + store fault: data address wins for addr
    tbl.push_back(mk(0,1,32'hbfc00900,32'h80000000,0,0,1,2,32'h80000001,0,0, 1,32'h82000000,32'h80000001,0,1,32'hbfc00900));
    // branch, bubble, Sys in slot, following instruction
    tbl.push_back(mk(0,1,32'hbfc00300,32'h0,       1,0,0,0,32'h0,       0,0, 1,32'h0,        32'h0,        0,0,32'hbfc00300));
    tbl.push_back(mk(0,0,32'h0,       32'h0,       0,0,0,0,32'h0,       0,0, 0,32'h0,        32'h0,        0,0,32'h0));
    tbl.push_back(mk(0,1,32'hbfc00304,32'h08000000,0,0,0,0,32'h0,       0,0, 1,32'h08000000,32'h0,        1,1,32'hbfc00304));
    tbl.push_back(mk(0,1,32'hbfc00308,32'h0,       0,0,0,0,32'h0,       0,0, 1,32'h0,        32'h0,        0,0,32'hbfc00308));
    // back-to-back branches
    tbl.push_back(mk(0,1,32'hbfc00500,32'h0,       1,0,0,0,32'h0,       0,0, 1,32'h0,        32'h0,        0,0,32'hbfc00500));
    tbl.push_back(mk(0,1,32'hbfc00504,32'h0,       1,0,0,0,32'h0,       0,0, 1,32'h0,        32'h0,        1,0,32'hbfc00504));
    tbl.push_back(mk(0,1,32'hbfc00508,32'h0,       0,0,0,0,32'h0,       0,0, 1,32'h0,        32'h0,        1,0,32'hbfc00508));
    tbl.push_back(mk(0,1,32'hbfc0050c,32'h0,       0,0,0,0,32'h0,       0,0, 1,32'h0,        32'h0,        0,0,32'hbfc0050c));
    // fetch fault, then flush with EX valid (pc held)
    tbl.push_back(mk(0,1,32'hbfc00402,32'h80000000,0,0,0,0,32'h0,       0,0, 1,32'h80000000,32'hbfc00402,0,1,32'hbfc00402));
    tbl.push_back(mk(0,1,32'hbfc00404,32'h40000000,0,0,0,0,32'h0,       0,1, 0,32'h0,        32'h0,        0,0,32'hbfc00402));

    foreach (tbl[i]) step(tbl[i]);

    // branch then flush: handler's first instruction is not a slot
    step(mk(0,1,32'hbfc00600,32'h0,       1,0,0,0,32'h0,0,0, 1,32'h0,32'h0,0,0,32'hbfc00600));
    step(mk(0,1,32'hbfc00604,32'h0,       0,0,0,0,32'h0,0,1, 0,32'h0,32'h0,0,0,32'hbfc00600));
    step(mk(0,1,32'h80000180,32'h0,       0,0,0,0,32'h0,0,0, 1,32'h0,32'h0,0,0,32'h80000180));

    // branch, stall, then slot still marked
    step(mk(0,1,32'hbfc00700,32'h0,       1,0,0,0,32'h0,0,0, 1,32'h0,32'h0,0,0,32'hbfc00700));
    step(mk(0,1,32'hbfc00704,32'h0,       0,0,0,0,32'h0,1,0, 1,32'h0,32'h0,0,0,32'hbfc00700));
    step(mk(0,1,32'hbfc00704,32'h0,       0,0,0,0,32'h0,0,0, 1,32'h0,32'h0,1,0,32'hbfc00704));

    // RI held through a 3-cycle stall, then flush during stall
    step(mk(0,1,32'hbfc00800,32'h40000000,0,0,0,0,32'h0,0,0, 1,32'h40000000,32'h0,0,1,32'hbfc00800));
    for (int k = 0; k < 3; k++)
      step(mk(0,1,32'hbfc00804,32'h0,     0,1,0,1,32'h80000001,1,0, 1,32'h40000000,32'h0,0,1,32'hbfc00800));
    step(mk(0,1,32'hbfc00804,32'h0,       0,0,0,0,32'h0,1,1, 0,32'h0,32'h0,0,0,32'hbfc00800));

    // reset mid-stream clears pc and the pending slot
    step(mk(0,1,32'hbfc00a00,32'h0,       1,0,0,0,32'h0,0,0, 1,32'h0,32'h0,0,0,32'hbfc00a00));
    step(mk(1,1,32'hbfc00a04,32'h0,       0,0,0,0,32'h0,0,0, 0,32'h0,32'h0,0,0,32'h0));
    step(mk(0,1,32'hbfc00a04,32'h0,       0,0,0,0,32'h0,0,0, 1,32'h0,32'h0,0,0,32'hbfc00a04));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_excep_stage.md
# mem_excep_stage

Pipeline register and exception collector between EX and the cp0 block. Captures each instruction leaving EX and adds data-address alignment checks to its exception vector. Tracks branch delay slots and presents exception type, PC, bad address and delay-slot flag to cp0 one cycle later. Also kills the memory access of any faulting instruction, and clears itself on cp0 flush.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- ex_valid_i  in  1  EX holds a real instruction (0 = bubble)
- ex_pc_i  in  32  PC of EX instruction
- ex_excep_i  in  32  upstream exception bits:
  - 31 fetch AdEL
  - 30 RI
  - 29 Ov
  - 28 Bp
  - 27 Sys
  - 0 ERET
  - all other bits are ignored
- ex_is_branch_i  in  1  instruction is a branch/jump with a delay slot
- ex_mem_rd_i  in  1  load
- ex_mem_wr_i  in  1  store
- ex_mem_size_i  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word
- ex_mem_addr_i  in  32  effective data address
- stall_i  in  1  hold stage contents
- flush_i  in  1  flush from cp0
- valid_o  out  1  stage holds a valid instruction
- pc_o  out  32  registered PC
- exception_type_o  out  32  exception vector to cp0; forced 0 when valid_o=0
- exception_addr_o  out  32  bad virtual address to cp0
- now_in_delayslot_o  out  1  registered instruction is a delay-slot instruction
- mem_kill_o  out  1  suppress data SRAM enable/write for the registered instruction

## Operation
- Registered state:
  - valid_r, pc_r, excep_r[31:0], addr_r, ds_r
  - slot_pending: the last captured valid instruction was a branch
- Alignment check, computed from EX inputs at capture:
  - misaligned = (size==1 & addr[0]) | (size>=2 & addr[1:0]!=0)
  - load & misaligned sets excep bit 26 (AdEL data)
  - store & misaligned sets excep bit 25 (AdES)
  - if rd and wr are both set, only bit 25 is raised
- excep_r = ex_excep_i with only bits 31,30,29,28,27,0 kept, OR the bits 26/25 computed above.
- addr_r:
  - ex_mem_addr_i if bit 26 or 25 is set
  - else ex_pc_i if bit 31 is set
  - else 0
- Delay slot:
  - a captured valid instruction gets ds_r = slot_pending
  - after capture, slot_pending = ex_is_branch_i
  - bubbles (ex_valid_i=0) are captured with valid_r=0, ds_r=0 and leave slot_pending unchanged
- Per-cycle priority: rst > flush_i > stall_i > capture.
  - rst or flush_i: valid_r=0, excep_r=0, addr_r=0, ds_r=0, slot_pending=0; pc_r keeps its value on flush, is 0 on rst
  - stall_i: every register holds
  - otherwise: capture the EX inputs
- Outputs:
  - exception_type_o = valid_r ? excep_r : 0
  - now_in_delayslot_o = valid_r & ds_r
  - mem_kill_o = valid_r & (excep_r != 0), including ERET
  - pc_o, exception_addr_o, valid_o come straight from registers
- No priority encoding in this block; cp0 resolves priority among reported bits.

## Timing
- Reset values: every output is 0.
- Latency: EX inputs at edge N appear on the outputs after edge N, for all of cycle N+1.
- Outputs are glitch-free registered values, except exception_type_o, now_in_delayslot_o and mem_kill_o, which are single AND-gates on registers.
- flush_i sampled at edge N gives valid_o=0 for cycle N+1, even if ex_valid_i=1 at that edge; that EX instruction is discarded.
- flush_i and stall_i both high: flush wins.
- Stall with a pending exception: exception_type_o stays asserted every stalled cycle. cp0 reacts only once because it sets its own EXL.
- Branch captured, then stalled, then the slot captured: the slot still gets ds=1.
- Branch followed by flush: slot_pending is cleared, so the handler's first instruction has ds=0.
- Two back-to-back branches: the second has ds=1, and slot_pending is then re-set by it.

## Test plan
- Reset, then idle: all outputs 0.
  - capture LW at pc 0xbfc00100, addr 0x80000004, no faults: valid_o=1, exception_type_o=0, mem_kill_o=0
- LH at pc 0xbfc00200, addr 0x80000001 -> next cycle:
  - exception_type_o = 0x04000000
  - exception_addr_o = 0x80000001
  - mem_kill_o = 1
- SW, addr 0x80000002: exception_type_o=0x02000000, exception_addr_o=0x80000002. SB at the same address: no exception.
- Sequence: branch at 0xbfc00300, bubble, then slot instruction at 0xbfc00304 with ex_excep_i bit 27 set.
  - slot cycle: now_in_delayslot_o=1 and exception_type_o=0x08000000
  - next instruction: ds=0
- Fetch fault: ex_excep_i=0x80000000 at pc 0xbfc00402 -> exception_addr_o=0xbfc00402, mem_kill_o=1. Then flush_i=1 while EX is valid -> next cycle valid_o=0, exception_type_o=0.
- Stall held 3 cycles while an RI instruction is registered: exception_type_o=0x40000000 in all 3 cycles. flush_i during the stall clears it on the next cycle.
